// File: rtl/h264chroma_sched_if.sv
// Source, predictor and status signals of h264chroma_sched; slave is the scheduler side.
// STALLCNT exists only when H264CHROMA_SCHED_STALLCNT_EN is defined.
interface h264chroma_sched_if;
    logic        START;
    logic        SVALID;
    logic [31:0] SDATA;
    logic        SREADY;
    logic        READYI;
    logic        XXINC;
    logic        STROBEI;
    logic [31:0] DATAI;
    logic        NEWSLICE;
    logic        NEWLINE;
    logic [7:0]  MBX;
    logic [7:0]  MBY;
    logic        BUSY;
    logic        DONE;
`ifdef H264CHROMA_SCHED_STALLCNT_EN
    logic [15:0] STALLCNT;
`endif

    modport slave (
        input  START, SVALID, SDATA, READYI, XXINC,
        output SREADY, STROBEI, DATAI, NEWSLICE, NEWLINE, MBX, MBY, BUSY, DONE
`ifdef H264CHROMA_SCHED_STALLCNT_EN
        , output STALLCNT
`endif
    );

    modport master (
        output START, SVALID, SDATA, READYI, XXINC,
        input  SREADY, STROBEI, DATAI, NEWSLICE, NEWLINE, MBX, MBY, BUSY, DONE
`ifdef H264CHROMA_SCHED_STALLCNT_EN
        , input STALLCNT
`endif
    );
endinterface

// File: rtl/h264chroma_sched.sv
// Feeds 32-word chroma macroblocks to the intra predictor; zero-latency word pass-through, pulses one cycle after START.
// Source stalls when READYI=0 or two macroblocks are unfinished; H264CHROMA_SCHED_STALLCNT_EN adds STALLCNT.
module h264chroma_sched #(
    parameter int MB_WIDTH  = 22,
    parameter int MB_HEIGHT = 18
) (
    input logic              CLK2,
    input logic              RESETN,
    h264chroma_sched_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SLICE, LINE, FEED, DRAIN, FIN} state_t;

    localparam logic [7:0] MB_W   = 8'(MB_WIDTH);
    localparam logic [7:0] X_LAST = 8'(MB_WIDTH - 1);
    localparam logic [7:0] Y_LAST = 8'(MB_HEIGHT - 1);

    state_t     state;
    logic [4:0] wcnt;
    logic [7:0] fed;
    logic [7:0] done;
    logic [7:0] mbx;
    logic [7:0] mby;
    logic [7:0] inflight;
    logic [7:0] done_nxt;
    logic       xfer;
    logic       done_inc;

    assign inflight = fed - done;
    assign xfer     = (state == FEED) && bus.SVALID && bus.READYI &&
                      (fed < MB_W) && (inflight < 8'd2);
    assign done_inc = bus.XXINC && ((state == FEED) || (state == DRAIN));
    assign done_nxt = done + {7'd0, done_inc};

    always_ff @(posedge CLK2 or negedge RESETN) begin
        if (!RESETN) begin
            state <= IDLE;
            wcnt  <= '0;
            fed   <= '0;
            done  <= '0;
            mbx   <= '0;
            mby   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        state <= SLICE;
                        mbx   <= '0;
                        mby   <= '0;
                    end
                end
                SLICE, LINE: begin
                    wcnt  <= '0;
                    fed   <= '0;
                    done  <= '0;
                    mbx   <= '0;
                    state <= FEED;
                end
                FEED: begin
                    done <= done_nxt;
                    if (xfer) begin
                        wcnt <= wcnt + 5'd1;
                        if (wcnt == 5'd31) begin
                            fed <= fed + 8'd1;
                            if (mbx != X_LAST) mbx <= mbx + 8'd1;
                            if (fed + 8'd1 == MB_W) state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Looking at done_nxt lets the line turn over right after the last XXINC.
                    done <= done_nxt;
                    if (done_nxt == MB_W) begin
                        if (mby == Y_LAST) begin
                            state <= FIN;
                        end else begin
                            mby   <= mby + 8'd1;
                            state <= LINE;
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.SREADY   = xfer;
    assign bus.STROBEI  = xfer;
    assign bus.DATAI    = bus.SDATA;
    assign bus.NEWSLICE = (state == SLICE);
    assign bus.NEWLINE  = (state == SLICE) || (state == LINE);
    assign bus.BUSY     = (state != IDLE);
    assign bus.DONE     = (state == FIN);
    assign bus.MBX      = mbx;
    assign bus.MBY      = mby;

`ifdef H264CHROMA_SCHED_STALLCNT_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge CLK2 or negedge RESETN) begin
        if (!RESETN) begin
            stall_cnt <= '0;
        end else if ((state == IDLE) && bus.START) begin
            stall_cnt <= '0;
        end else if ((state == FEED) && bus.SVALID && !bus.READYI &&
                     (fed < MB_W) && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign bus.STALLCNT = stall_cnt;
`endif
endmodule

// File: tb/tb_h264chroma_sched.sv
// Scoreboard bench: frames of random words are queued as expected (data, MBX, MBY) and pulse sequences;
// a negedge monitor pops and compares while a predictor model issues XXINC after each finished macroblock.
module tb_h264chroma_sched;
    localparam int W   = 3;
    localparam int H   = 2;
    localparam int WPL = 32 * W;

    logic CLK2   = 1'b0;
    logic RESETN = 1'b0;
    always #5 CLK2 = ~CLK2;

    h264chroma_sched_if bus ();
    h264chroma_sched #(.MB_WIDTH(W), .MB_HEIGHT(H)) dut (.CLK2(CLK2), .RESETN(RESETN), .bus(bus));

    typedef struct { logic [31:0] dat; int x; int y; } word_t;
    typedef struct { logic ns; logic nl; logic dn; int y; } pulse_t;

    word_t       exp_q[$];
    pulse_t      ev_q[$];
    logic [31:0] src_words[$];
    int          xx_due[$];

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int src_idx = 0, line_strobes = 0, line_xx = 0, frame_strobes = 0;
    int stall_model = 0, done_seen = 0, last_xx_cyc = 0, slice_cyc = 0, last_due = 0;
    int vld_pct = 100, rdy_pct = 100, xx_max = 40;
    bit feeding = 0, first_word = 0, toggle_rdy = 0, hold_xx = 0, force_xx = 0, full_rate = 0;

    always @(posedge CLK2) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_strobei"},  bus.STROBEI,  1'b0);
        check({tag, "_sready"},   bus.SREADY,   1'b0);
        check({tag, "_newslice"}, bus.NEWSLICE, 1'b0);
        check({tag, "_newline"},  bus.NEWLINE,  1'b0);
        check({tag, "_done"},     bus.DONE,     1'b0);
        check({tag, "_busy"},     bus.BUSY,     1'b0);
        check({tag, "_mbx"},      bus.MBX,      8'd0);
        check({tag, "_mby"},      bus.MBY,      8'd0);
        check({tag, "_datai"},    bus.DATAI,    bus.SDATA);
`ifdef H264CHROMA_SCHED_STALLCNT_EN
        check({tag, "_stallcnt"}, bus.STALLCNT, 16'd0);
`endif
    endtask

    // Source and predictor driver: changes inputs 1 time unit after each rising edge.
    initial begin
        bus.SVALID = 1'b0;
        bus.SDATA  = '0;
        bus.READYI = 1'b0;
        bus.XXINC  = 1'b0;
        forever begin
            @(posedge CLK2);
            #1;
            bus.READYI = toggle_rdy ? ~bus.READYI : ($urandom_range(99) < rdy_pct);
            bus.SVALID = (src_idx < src_words.size()) && ($urandom_range(99) < vld_pct);
            bus.SDATA  = bus.SVALID ? src_words[src_idx] : $urandom;
            bus.XXINC  = force_xx;
            if (!hold_xx && xx_due.size() > 0 && cyc >= xx_due[0]) begin
                bus.XXINC = 1'b1;
                void'(xx_due.pop_front());
            end
        end
    end

    // Monitor: compares every observed word and pulse against the queued expectations.
    initial forever begin
        word_t  e;
        pulse_t p;
        int     due;
        @(negedge CLK2);
        if (RESETN) begin
            check("datai_pass", bus.DATAI, bus.SDATA);
            check("sready_eq_strobe", bus.SREADY, bus.STROBEI);
            check("strobe_newline_excl", bus.STROBEI & bus.NEWLINE, 1'b0);
            if (feeding && bus.SVALID && !bus.READYI) stall_model++;
            if (bus.STROBEI) begin
                check("strobe_handshake", bus.SVALID & bus.READYI, 1'b1);
                check("inflight_lt2", (line_strobes / 32 - line_xx) < 2, 1'b1);
                if (first_word && full_rate) check("first_strobe_latency", cyc - slice_cyc, 1);
                first_word = 0;
                check("word_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("word_data", bus.DATAI, e.dat);
                    check("word_mbx", bus.MBX, e.x);
                    check("word_mby", bus.MBY, e.y);
                end
                src_idx++;
                line_strobes++;
                frame_strobes++;
                if (line_strobes % 32 == 0) begin
                    due = cyc + int'($urandom_range(xx_max, 1));
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    xx_due.push_back(due);
                end
                if (line_strobes == WPL) feeding = 0;
            end
            if (bus.XXINC) begin
                line_xx++;
                last_xx_cyc = cyc;
            end
            if (bus.NEWSLICE || bus.NEWLINE || bus.DONE) begin
                check("pulse_expected", ev_q.size() > 0, 1'b1);
                if (ev_q.size() > 0) begin
                    p = ev_q.pop_front();
                    check("pulse_kind", {bus.NEWSLICE, bus.NEWLINE, bus.DONE}, {p.ns, p.nl, p.dn});
                    check("pulse_mby", bus.MBY, p.y);
                end
                if (!bus.NEWSLICE) begin
                    check("line_complete", line_xx, W);
                    check("pulse_after_last_xxinc", cyc - last_xx_cyc, 1);
                end
                if (bus.NEWSLICE) begin
                    slice_cyc  = cyc;
                    first_word = 1;
                end
                if (bus.NEWLINE) begin
                    line_strobes = 0;
                    line_xx      = 0;
                    feeding      = 1;
                end
                if (bus.DONE) done_seen++;
            end
        end
    end

    task automatic run_frame(input int vp, input int rp, input bit tog, input bit hold,
                             input bit poke, input int abort_at);
        int n;
        int c;
        @(posedge CLK2);
        #1;
        src_words.delete();
        exp_q.delete();
        ev_q.delete();
        xx_due.delete();
        vld_pct    = vp;
        rdy_pct    = rp;
        toggle_rdy = tog;
        full_rate  = (vp == 100 && rp == 100 && !tog);
        for (int k = 0; k < W * H * 32; k++) begin
            logic [31:0] w;
            w = $urandom;
            src_words.push_back(w);
            exp_q.push_back('{w, (k % WPL) / 32, k / WPL});
        end
        ev_q.push_back('{1'b1, 1'b1, 1'b0, 0});
        for (int l = 1; l < H; l++) ev_q.push_back('{1'b0, 1'b1, 1'b0, l});
        ev_q.push_back('{1'b0, 1'b0, 1'b1, H - 1});
        src_idx       = 0;
        stall_model   = 0;
        frame_strobes = 0;
        last_due      = 0;
        n             = done_seen;
        bus.START     = 1'b1;
        @(posedge CLK2);
        #1 bus.START = 1'b0;
        @(negedge CLK2);
        #1;
        check("start_newslice", bus.NEWSLICE, 1'b1);
        check("start_busy", bus.BUSY, 1'b1);

        if (poke) begin
            repeat (5) @(posedge CLK2);
            #1 bus.START = 1'b1;
            @(posedge CLK2);
            #1 bus.START = 1'b0;
        end

        if (hold) begin
            hold_xx = 1;
            repeat (150) @(negedge CLK2);
            #1;
            check("hold_words", frame_strobes, 64);
            check("hold_sready", bus.SREADY, 1'b0);
            hold_xx = 0;
        end

        if (abort_at > 0) begin
            c = 0;
            while (frame_strobes < abort_at && c < 5000) begin
                @(negedge CLK2);
                #1;
                c++;
            end
            check("abort_reached", frame_strobes >= abort_at, 1'b1);
            RESETN = 1'b0;
            #1;
            check_reset_vals("abort");
            src_words.delete();
            exp_q.delete();
            ev_q.delete();
            xx_due.delete();
            src_idx = 0;
            feeding = 0;
            repeat (2) @(negedge CLK2);
            #1;
            check_reset_vals("abort_hold");
            RESETN = 1'b1;
            return;
        end

        c = 0;
        while (done_seen == n && c < 20000) begin
            @(negedge CLK2);
            #1;
            c++;
        end
        check("frame_done", done_seen - n, 1);
        check("busy_in_fin", bus.BUSY, 1'b1);
        @(negedge CLK2);
        #1;
        check("busy_after_done", bus.BUSY, 1'b0);
        check("done_one_cycle", bus.DONE, 1'b0);
        check("words_left", exp_q.size(), 0);
        check("pulses_left", ev_q.size(), 0);
        check("frame_words", frame_strobes, W * H * 32);
`ifdef H264CHROMA_SCHED_STALLCNT_EN
        check("stallcnt", bus.STALLCNT, stall_model);
`endif
    endtask

    initial begin
        bus.START = 1'b0;
        RESETN    = 1'b0;
        #12;
        check_reset_vals("reset");
        @(negedge CLK2);
        #1 RESETN = 1'b1;

        // XXINC while idle must leave the scheduler untouched.
        @(negedge CLK2);
        force_xx = 1;
        repeat (3) @(negedge CLK2);
        force_xx = 0;
        #1;
        check("idle_busy", bus.BUSY, 1'b0);
        check("idle_mbx", bus.MBX, 8'd0);

        run_frame(70, 70, 0, 0, 1, 0);
        run_frame(100, 100, 0, 1, 0, 0);
        run_frame(100, 0, 1, 0, 0, 0);
        run_frame(100, 100, 0, 0, 0, 11);
        run_frame(100, 100, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/h264chroma_sched.md
# h264chroma_sched

Input scheduler for the chroma intra 8x8 predictor. It moves chroma macroblock words from an upstream valid/ready source into the predictor: 32 words per macroblock, Cb words 0..15 first, then Cr words 16..31. It issues the slice-start and line-start pulses and counts macroblock positions across a frame. It keeps at most one macroblock in flight beyond the one the predictor has completed.

## Interface
Parameters:
- MB_WIDTH, 22, macroblocks per line (1..255)
- MB_HEIGHT, 18, macroblock lines per frame (1..255)

Ports:
- CLK2  in  1  clock, rising edge
- RESETN  in  1  asynchronous active-low reset
- START  in  1  one-cycle pulse, begins a frame/slice; ignored unless IDLE
- SVALID  in  1  source word valid
- SDATA  in  32  source word
- SREADY  out  1  source word accepted this cycle
- READYI  in  1  predictor can accept a word
- XXINC  in  1  predictor finished one macroblock (one-cycle pulse)
- STROBEI  out  1  word write strobe to predictor
- DATAI  out  32  word to predictor
- NEWSLICE  out  1  slice-start pulse
- NEWLINE  out  1  line-start pulse
- MBX  out  8  column of the macroblock currently being fed
- MBY  out  8  current macroblock line
- BUSY  out  1  frame in progress
- DONE  out  1  one-cycle pulse after the last macroblock completes
- STALLCNT  out  16  stall counter; present only with the macro

## Operation
- FSM states: IDLE, SLICE, LINE, FEED, DRAIN, FIN.
- IDLE: START -> SLICE. MBX/MBY cleared on entry to SLICE.
- SLICE (1 cycle): NEWSLICE=1 and NEWLINE=1 -> FEED.
- LINE (1 cycle): NEWLINE=1 only, MBX cleared -> FEED.
- FEED: xfer = SVALID & READYI & (fed < MB_WIDTH) & (fed - done < 2). STROBEI = SREADY = xfer (combinational). DATAI = SDATA (combinational pass-through).
  - Per xfer, 5-bit wcnt increments.
  - When wcnt=31 transfers: wcnt wraps to 0, fed increments, MBX increments saturating at MB_WIDTH-1.
  - When fed reaches MB_WIDTH -> DRAIN.
- fed and done are 8-bit counts, cleared in SLICE/LINE. done increments on each XXINC in FEED or DRAIN; XXINC in any other state is ignored.
- DRAIN: wait until done == MB_WIDTH.
  - If MBY == MB_HEIGHT-1 -> FIN.
  - Else MBY increments -> LINE.
  - NEWLINE is never asserted while a macroblock is incomplete, because it resets the predictor.
- FIN (1 cycle): DONE=1 -> IDLE.
- STROBEI and NEWLINE are never high in the same cycle.
- Simultaneous xfer of word 31 and XXINC: fed and done both update; the in-flight difference stays consistent.
- START while not IDLE: ignored. SVALID outside FEED: SREADY=0.

## Timing
- Reset values: STROBEI, SREADY, NEWSLICE, NEWLINE, DONE, BUSY = 0; MBX, MBY = 0; STALLCNT = 0; DATAI follows SDATA. FSM = IDLE; wcnt, fed, done = 0.
- RESETN low mid-frame: immediate abort to IDLE, all counters cleared. The predictor is resynchronised by the next SLICE pulse.
- START at edge t -> NEWSLICE/NEWLINE high in cycle t+1 -> first possible STROBEI in cycle t+2.
- Transfers have zero latency. Peak rate is one word per cycle while READYI=1.
- BUSY=1 from SLICE through FIN inclusive.
- Last XXINC of the line at edge t -> LINE in cycle t+1 (NEWLINE high) -> FEED in cycle t+2.

## Configuration
- H264CHROMA_SCHED_STALLCNT_EN defined:
  - STALLCNT counts cycles in FEED with SVALID=1, READYI=0 and fed < MB_WIDTH.
  - Saturates at 0xFFFF. Cleared on START accepted in IDLE.
- Undefined: STALLCNT port and its logic are absent; all other behaviour is identical.

## Test plan
- MB_WIDTH=2, MB_HEIGHT=1, SVALID and READYI always 1, XXINC modelled 40 cycles after each 32nd word -> NEWSLICE+NEWLINE once, 64 STROBEI with DATAI = SDATA, no NEWLINE mid-line, DONE one cycle after the 2nd XXINC then LINE/FIN exit, BUSY falls with DONE.
- MB_WIDTH=3, XXINC withheld -> exactly 64 words accepted, SREADY stays 0 until the first XXINC, then the third macroblock streams.
- MB_WIDTH=1, MB_HEIGHT=3 -> NEWLINE pulses at frame start plus 2 line starts, NEWSLICE once, MBY sequence 0,1,2, DONE once.
- READYI toggled every cycle -> STROBEI only in cycles with READYI=1, word order preserved 0..31; with the macro, STALLCNT = count of stalled cycles (e.g. 31).
- RESETN pulsed low after word 10 -> all outputs at reset values. A new START restarts with wcnt=0, MBX=0, MBY=0.
- START asserted during FEED -> no effect; XXINC in IDLE -> done count unchanged.
